inst_boot_loader: RTL and testbench
===================================

# inst_boot_loader

Boot-time loader that sits directly upstream of the minimal SoC's instruction ROM and CPU reset. It accepts a framed byte stream on a valid/ready interface, packs bytes into 32-bit big-endian instruction words, and writes them sequentially into instruction memory from word address 0. It verifies an XOR checksum and releases the CPU from reset only after a fully valid image has been written. On synthesizable targets it replaces the simulation-only `$readmemh` preload.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high (`RstEnable` = 1'b1).
- `byte_data`  in  8: incoming stream byte.
- `byte_valid`  in  1: `byte_data` is valid this cycle.
- `byte_ready`  out  1: loader accepts a byte this cycle. A byte is consumed when `byte_valid && byte_ready`.
- `mem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH: word address of the write.
- `mem_wdata`  out  32: instruction word.
- `cpu_rst`  out  1: active-high reset to the CPU core. Held at 1 until the load succeeds.
- `done`  out  1: sticky. Image loaded and checksum correct.
- `error`  out  1: sticky. Length overflow or checksum mismatch.

## Operation
- Frame format: `LEN_HI`, `LEN_LO` (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then 1 checksum byte.
- Checksum = XOR of all 4·N data bytes. Length bytes are excluded.
- FSM states: `S_LEN_HI` → `S_LEN_LO` → `S_DATA` → `S_CSUM` → `S_DONE`. `S_ERR` is the failure state.
- `S_LEN_LO` on accept:
  - N > 2^ADDR_WIDTH → `S_ERR`.
  - N == 0 → `S_CSUM`.
  - otherwise → `S_DATA`.
- `S_DATA`:
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On the 4th byte, the word is issued and the word counter increments.
  - After word N-1 is issued → `S_CSUM`.
- `S_CSUM` on accept:
  - Running XOR equals the received byte → `S_DONE`.
  - Otherwise → `S_ERR`.
  - For N = 0 the expected byte is 0x00.
- `S_DONE` and `S_ERR` are terminal until `rst`. In both, `byte_ready` = 0 and `byte_valid` is ignored.
- `byte_ready` = 1 in the `S_LEN_HI`, `S_LEN_LO`, `S_DATA` and `S_CSUM` states. The loader never stalls the source.
- `mem_addr` runs 0..N-1 with no wrap. The overflow check guarantees this.
- Reset values (also on `rst` mid-load):
  - state `S_LEN_HI`, all counters and the XOR register 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_rst` = 1, `done` = 0, `error` = 0.
  - `byte_ready` = 0 during the reset cycle.
- Partially written memory after a mid-load reset is not cleared. The next load overwrites it.

## Timing
- All outputs are registered except `byte_ready`, which decodes the current state.
- Word write latency: 4th data byte accepted at edge k → `mem_we` = 1, with `mem_addr`/`mem_wdata` valid, for exactly the cycle after edge k. `mem_we` returns to 0 on the next edge unless another word completes.
- Back-to-back bytes give at most one write per 4 cycles. Gaps in `byte_valid` stretch this and never lose data.
- Checksum accepted at edge k:
  - Success: `done` = 1 and `cpu_rst` = 0 from the cycle after edge k.
  - Failure: `error` = 1 from the cycle after edge k, and `cpu_rst` stays 1.
- Length overflow: `error` = 1 the cycle after the `LEN_LO` accept. No memory writes occur.
- `done` and `error` are never 1 simultaneously.

## Structure
- Shared `defines.v` holds:
  - the loader state encodings (`S_LEN_HI` … `S_ERR`, 3 bits);
  - `RstEnable`/`RstDisable`;
  - `InstBus` (32-bit) width macro.
- Sub-module `boot_word_packer`:
  - byte shift register plus 2-bit counter;
  - emits a one-cycle `word_valid` with the 32-bit word.
  - The FSM, counters, checksum and outputs stay in `inst_boot_loader`.

## Test plan
- N = 1 (`00 01`), bytes `34 01 11 00`, checksum `24`, streamed back-to-back.
  - Expect one write: `mem_addr` 0, `mem_wdata` 0x34011100.
  - Then `done` = 1 and `cpu_rst` = 0 one cycle after the checksum byte.
- N = 3 with random `byte_valid` gaps:
  - Expect writes at addresses 0, 1, 2 with the correct words, in order.
  - `done` = 1, `error` = 0.
- N = 1 with checksum `25` (wrong):
  - Expect the write at address 0 to still occur.
  - `error` = 1, `cpu_rst` stays 1, `byte_ready` = 0 afterwards.
- ADDR_WIDTH = 10, N = 0x0401:
  - Expect `error` = 1 one cycle after `LEN_LO`, zero `mem_we` pulses, further bytes ignored.
- N = 0 (`00 00`) with checksum `00`:
  - Expect no writes, `done` = 1, `cpu_rst` = 0.
- Assert `rst` after 2 of 4 data bytes, then send a fresh N = 1 frame.
  - Expect all outputs at their reset values for the reset cycle.
  - The fresh frame loads correctly, with no stale bytes in the first word.

Source files
------------

// File: rtl/inst_boot_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_boot_loader_pkg;

  localparam int unsigned INST_BUS_W = 32;
  localparam int unsigned LEN_W      = 16;
  localparam logic        RST_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/inst_boot_loader_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; one-cycle word_valid per word.
module boot_word_packer
  import inst_boot_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_data,
  input  logic                  byte_en,
  output logic                  word_valid,
  output logic [INST_BUS_W-1:0] word,
  output logic                  last_byte_c
);

  logic [23:0] shift;
  logic [1:0]  cnt;

  // High when the byte being accepted completes a word.
  assign last_byte_c = byte_en && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      shift      <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        shift <= {shift[15:0], byte_data};
        cnt   <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          word       <= {shift, byte_data};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_boot_loader.sv
// Framed byte-stream loader: writes instruction words from address 0, checks an
// XOR checksum, and releases the CPU reset only after a valid image.
module inst_boot_loader
  import inst_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_BUS_W-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len_n;
  logic [LEN_W-1:0] len_last;
  logic [CNT_W-1:0] word_cnt;
  logic [7:0]       csum;
  logic             pack_en;
  logic             last_byte_c;
  logic             word_is_last;

  assign accept       = byte_valid && byte_ready;
  assign len_n        = {len_hi, byte_data};
  assign pack_en      = accept && (state == S_DATA);
  assign word_is_last = (32'(word_cnt) == 32'(len_last));

  boot_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .byte_data   (byte_data),
    .byte_en     (pack_en),
    .word_valid  (mem_we),
    .word        (mem_wdata),
    .last_byte_c (last_byte_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= S_LEN_HI;
    else                   state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (32'(len_n) > CAPACITY) state_next = S_ERR;
          else if (len_n == '0)      state_next = S_CSUM;
          else                       state_next = S_DATA;
        end
      end
      S_DATA:   if (last_byte_c && word_is_last) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) state_next = (csum == byte_data) ? S_DONE : S_ERR;
      end
      default:  state_next = state;
    endcase
  end

  // Ready decodes the current state; deasserted while reset is held.
  always_comb begin
    byte_ready = 1'b0;
    if (rst != RST_ENABLE) begin
      case (state)
        S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: byte_ready = 1'b1;
        default:                            byte_ready = 1'b0;
      endcase
    end
  end

  // Length capture, word counter, address and running checksum.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      len_hi   <= '0;
      len_last <= '0;
      word_cnt <= '0;
      csum     <= '0;
      mem_addr <= '0;
    end else if (accept) begin
      case (state)
        S_LEN_HI: len_hi <= byte_data;
        S_LEN_LO: len_last <= LEN_W'(len_n - 16'd1);
        S_DATA: begin
          csum <= csum ^ byte_data;
          if (last_byte_c) begin
            mem_addr <= word_cnt[ADDR_WIDTH-1:0];
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      cpu_rst <= (state_next != S_DONE);
      done    <= (state_next == S_DONE);
      error   <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Self-checking bench for inst_boot_loader with a frame-level reference model.
module tb_inst_boot_loader;

  localparam int CAP = 1024;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [7:0] frame[$];
  logic [7:0] frame_a [7] = '{8'h00, 8'h01, 8'h34, 8'h01, 8'h11, 8'h00, 8'h24};

  inst_boot_loader #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write strobes are a full cycle wide, so one negedge sample per pulse.
  always @(negedge clk) if (mem_we === 1'b1) we_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b0;
    #1 check("ready_in_rst", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", mem_wdata,      32'd0);
    check("rst_cpu",   32'(cpu_rst),   32'd1);
    check("rst_done",  32'(done),      32'd0);
    check("rst_error", 32'(error),     32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int waits = 0;
    ok = 1'b0;
    while (!ok && waits < 200) begin
      @(negedge clk);
      byte_data  = b;
      byte_valid = ($urandom_range(99) >= gap);
      ok = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int d = 0; d < 4 * n; d++) begin
      b = 8'($urandom);
      x ^= b;
      frame.push_back(b);
    end
    frame.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // Reference: parse the frame as a whole, then check each accepted byte's effect.
  task automatic send_frame(input int gap);
    int n, base, d, limit;
    bit ovf, good, ok;
    logic [7:0] x = 8'h00;
    logic [31:0] w;
    n    = int'({frame[0], frame[1]});
    ovf  = (n > CAP);
    if (!ovf) for (int k = 0; k < 4 * n; k++) x ^= frame[2 + k];
    good  = !ovf && (x == frame[2 + 4 * n]);
    base  = we_count;
    limit = ovf ? 2 : frame.size();
    for (int i = 0; i < limit; i++) begin
      send_byte(frame[i], gap, ok);
      if (!ok) break;
      if (i < 2) check("len_we", 32'(mem_we), 32'd0);
      if (i == 1) check("len_error", 32'(error), ovf ? 32'd1 : 32'd0);
      if (i >= 2 && i < 2 + 4 * n) begin
        d = i - 2;
        if (d % 4 == 3) begin
          w = {frame[i - 3], frame[i - 2], frame[i - 1], frame[i]};
          check("word_we",    32'(mem_we),   32'd1);
          check("word_addr",  32'(mem_addr), 32'(d / 4));
          check("word_wdata", mem_wdata,     w);
        end else begin
          check("byte_we", 32'(mem_we), 32'd0);
        end
        check("busy_cpu_rst", 32'(cpu_rst), 32'd1);
      end
      if (!ovf && i == 2 + 4 * n) begin
        check("csum_done",  32'(done),    good ? 32'd1 : 32'd0);
        check("csum_error", 32'(error),   good ? 32'd0 : 32'd1);
        check("csum_cpu",   32'(cpu_rst), good ? 32'd0 : 32'd1);
        check("csum_we",    32'(mem_we),  32'd0);
      end
    end
    // Terminal state: further bytes are refused and nothing changes.
    repeat (3) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      check("idle_ready", 32'(byte_ready), 32'd0);
      @(posedge clk);
      #1;
      check("idle_we",    32'(mem_we), 32'd0);
      check("idle_done",  32'(done),   good ? 32'd1 : 32'd0);
      check("idle_error", 32'(error),  good ? 32'd0 : 32'd1);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    check("we_pulses", 32'(we_count - base), ovf ? 32'd0 : 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    do_reset();

    // N=1 known image, back-to-back.
    frame.delete();
    foreach (frame_a[i]) frame.push_back(frame_a[i]);
    send_frame(0);

    // N=3 with gaps.
    do_reset();
    build_frame(3, 1'b0);
    send_frame(40);

    // N=1 with wrong checksum 0x25.
    do_reset();
    frame.delete();
    foreach (frame_a[i]) frame.push_back(frame_a[i]);
    frame[6] = 8'h25;
    send_frame(0);

    // Length overflow 0x0401.
    do_reset();
    frame.delete();
    frame.push_back(8'h04);
    frame.push_back(8'h01);
    send_frame(0);

    // Empty image.
    do_reset();
    frame.delete();
    repeat (3) frame.push_back(8'h00);
    send_frame(0);

    // Reset after two data bytes, then a fresh frame.
    do_reset();
    build_frame(1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0, ok);
    do_reset();
    build_frame(1, 1'b0);
    send_frame(0);

    // Randomized frames.
    repeat (6) begin
      do_reset();
      build_frame($urandom_range(1, 8), ($urandom_range(3) == 0));
      send_frame($urandom_range(0, 50));
    end

    // Full capacity.
    do_reset();
    build_frame(CAP, 1'b0);
    send_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
